// File: rtl/mismatch_monitor_mc.sv
// Multi-channel run-length monitor for mismatch events: per-channel run counter,
// peak register and OK/BLOCKED state, plus a shared saturating trip-event counter.
module mismatch_monitor_mc #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned STICKY = 0,
    parameter int unsigned TRIP_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         valid,
    input  logic [N_CH-1:0]         match,
    input  logic [CNT_W-1:0]        thresh,
    input  logic [N_CH-1:0]         clr,
    input  logic                    max_clr,
    output logic [N_CH*CNT_W-1:0]   count_o,
    output logic [N_CH*CNT_W-1:0]   max_o,
    output logic [N_CH-1:0]         block,
    output logic                    block_any,
    output logic [TRIP_W-1:0]       trip_cnt
);

    typedef enum logic {
        ST_OK,
        ST_BLOCKED
    } state_t;

    logic [CNT_W-1:0]  count_q [N_CH];
    logic [CNT_W-1:0]  count_d [N_CH];
    logic [CNT_W-1:0]  max_q   [N_CH];
    logic [CNT_W-1:0]  max_d   [N_CH];
    state_t            state_q [N_CH];
    state_t            state_d [N_CH];
    logic [TRIP_W-1:0] trip_cnt_q;
    logic [TRIP_W-1:0] trip_cnt_d;

    always_comb begin
        logic [CNT_W-1:0] nxt;
        logic             trip;
        nxt        = '0;
        trip       = 1'b0;
        trip_cnt_d = trip_cnt_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            nxt = (count_q[i] == '1) ? count_q[i] : count_q[i] + CNT_W'(1);

            if (clr[i])
                count_d[i] = '0;
            else if (!valid[i])
                count_d[i] = count_q[i];
            else if (match[i])
                count_d[i] = '0;
            else
                count_d[i] = nxt;

            // Trip compares the post-increment count so block rises on the same edge the count reaches thresh.
            trip = !clr[i] && valid[i] && !match[i] && (thresh != '0) &&
                   (nxt >= thresh) && (state_q[i] == ST_OK);

            state_d[i] = state_q[i];
            if (clr[i])
                state_d[i] = ST_OK;
            else if (trip)
                state_d[i] = ST_BLOCKED;
            else if ((state_q[i] == ST_BLOCKED) && (STICKY == 0) && valid[i] && match[i])
                state_d[i] = ST_OK;

            if (max_clr)
                max_d[i] = '0;
            else if (count_q[i] > max_q[i])
                max_d[i] = count_q[i];
            else
                max_d[i] = max_q[i];

            if (trip && (trip_cnt_d != '1))
                trip_cnt_d = trip_cnt_d + TRIP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                count_q[i] <= '0;
                max_q[i]   <= '0;
                state_q[i] <= ST_OK;
            end
            trip_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                count_q[i] <= count_d[i];
                max_q[i]   <= max_d[i];
                state_q[i] <= state_d[i];
            end
            trip_cnt_q <= trip_cnt_d;
        end
    end

    always_comb begin
        count_o = '0;
        max_o   = '0;
        block   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            count_o[i*CNT_W +: CNT_W] = count_q[i];
            max_o[i*CNT_W +: CNT_W]   = max_q[i];
            block[i]                  = (state_q[i] == ST_BLOCKED);
        end
    end

    assign block_any = |block;
    assign trip_cnt  = trip_cnt_q;

endmodule

// File: tb/tb_mismatch_monitor_mc.sv
// Bench for mismatch_monitor_mc: a non-sticky and a sticky instance share the stimulus;
// directed steps queue hand-computed expectations, a negedge monitor pops and checks them.
module tb_mismatch_monitor_mc;

    localparam int K_CNT  = 0;
    localparam int K_MAX  = 1;
    localparam int K_BLK  = 2;
    localparam int K_ANY  = 3;
    localparam int K_TRIP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid, match, clr;
    logic [7:0]  thresh;
    logic        max_clr;

    logic [31:0] c0, c1, m0, m1;
    logic [3:0]  b0, b1;
    logic        a0, a1;
    logic [15:0] t0, t1;

    typedef struct {
        string name;
        int    dut;
        int    kind;
        int    ch;
        int    val;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mismatch_monitor_mc #(.N_CH(4), .CNT_W(8), .STICKY(0), .TRIP_W(16)) u_ns (
        .clk(clk), .rst_n(rst_n), .valid(valid), .match(match), .thresh(thresh),
        .clr(clr), .max_clr(max_clr), .count_o(c0), .max_o(m0), .block(b0),
        .block_any(a0), .trip_cnt(t0)
    );

    mismatch_monitor_mc #(.N_CH(4), .CNT_W(8), .STICKY(1), .TRIP_W(16)) u_st (
        .clk(clk), .rst_n(rst_n), .valid(valid), .match(match), .thresh(thresh),
        .clr(clr), .max_clr(max_clr), .count_o(c1), .max_o(m1), .block(b1),
        .block_any(a1), .trip_cnt(t1)
    );

    function automatic int act(int dut, int kind, int ch);
        logic [31:0] c, m;
        logic [3:0]  b;
        c = dut ? c1 : c0;
        m = dut ? m1 : m0;
        b = dut ? b1 : b0;
        case (kind)
            K_CNT:   return int'(c[ch*8 +: 8]);
            K_MAX:   return int'(m[ch*8 +: 8]);
            K_BLK:   return int'(b[ch]);
            K_ANY:   return dut ? int'(a1) : int'(a0);
            default: return dut ? int'(t1) : int'(t0);
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   a;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = act(e.dut, e.kind, e.ch);
            checks++;
            if (a != e.val) begin
                errors++;
                $display("FAIL %s (dut%0d ch%0d): got %0d expected %0d", e.name, e.dut, e.ch, a, e.val);
            end
        end
    end

    task automatic chk(input string n, input int d, input int k, input int ch, input int v);
        q.push_back('{n, d, k, ch, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        valid = '0; match = '0; clr = '0; max_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with random inputs
        rst_n   = 1'b0;
        valid   = 4'($urandom);
        match   = 4'($urandom);
        clr     = 4'($urandom);
        thresh  = 8'($urandom);
        max_clr = 1'($urandom);
        tick();
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 4; ch++) begin
                chk("rst_cnt", d, K_CNT, ch, 0);
                chk("rst_max", d, K_MAX, ch, 0);
                chk("rst_blk", d, K_BLK, ch, 0);
            end
            chk("rst_any", d, K_ANY, 0, 0);
            chk("rst_trip", d, K_TRIP, 0, 0);
        end
        rst_n = 1'b1;
        quiet();

        // Basic trip and release on ch0
        thresh = 8'd10;
        valid  = 4'b0001;
        repeat (9) tick();
        chk("t2_cnt9", 0, K_CNT, 0, 9);
        chk("t2_blk_pre", 0, K_BLK, 0, 0);
        tick();
        chk("t2_cnt10", 0, K_CNT, 0, 10);
        chk("t2_blk", 0, K_BLK, 0, 1);
        chk("t2_any", 0, K_ANY, 0, 1);
        chk("t2_trip", 0, K_TRIP, 0, 1);
        chk("t2_max_lag", 0, K_MAX, 0, 9);
        match = 4'b0001;
        tick();
        chk("t2_cnt_clr", 0, K_CNT, 0, 0);
        chk("t2_release", 0, K_BLK, 0, 0);
        chk("t2_any_off", 0, K_ANY, 0, 0);
        chk("t2_max", 0, K_MAX, 0, 10);
        chk("t2_sticky_hold", 1, K_BLK, 0, 1);
        quiet();
        do_reset();

        // Saturation with blocking disabled
        thresh = 8'd0;
        valid  = 4'b0010;
        repeat (300) tick();
        chk("t3_cnt_sat", 0, K_CNT, 1, 255);
        chk("t3_noblk", 0, K_BLK, 1, 0);
        chk("t3_max_sat", 0, K_MAX, 1, 255);
        chk("t3_trip0", 0, K_TRIP, 0, 0);
        quiet();
        do_reset();

        // Valid gaps hold the count
        thresh = 8'd10;
        valid  = 4'b0001;
        repeat (5) tick();
        chk("t4_cnt5", 0, K_CNT, 0, 5);
        valid = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_gap_hold", 0, K_CNT, 0, 5);
            chk("t4_gap_blk", 0, K_BLK, 0, 0);
        end
        valid = 4'b0001;
        repeat (4) tick();
        chk("t4_cnt9", 0, K_CNT, 0, 9);
        chk("t4_blk_pre", 0, K_BLK, 0, 0);
        tick();
        chk("t4_cnt10", 0, K_CNT, 0, 10);
        chk("t4_blk", 0, K_BLK, 0, 1);
        chk("t4_trip", 0, K_TRIP, 0, 1);
        quiet();
        do_reset();

        // Sticky hold, clear, and clear beating a trip on ch2
        thresh = 8'd10;
        valid  = 4'b0100;
        repeat (10) tick();
        chk("t5_blk", 1, K_BLK, 2, 1);
        chk("t5_trip", 1, K_TRIP, 0, 1);
        match = 4'b0100;
        repeat (3) tick();
        chk("t5_sticky", 1, K_BLK, 2, 1);
        chk("t5_cnt0", 1, K_CNT, 2, 0);
        chk("t5_nonsticky", 0, K_BLK, 2, 0);
        valid = '0; match = '0; clr = 4'b0100;
        tick();
        chk("t5_clr_blk", 1, K_BLK, 2, 0);
        chk("t5_clr_cnt", 1, K_CNT, 2, 0);
        clr   = '0;
        valid = 4'b0100;
        repeat (9) tick();
        chk("t5_cnt9", 1, K_CNT, 2, 9);
        clr = 4'b0100;
        tick();
        chk("t5_clrwin_cnt", 1, K_CNT, 2, 0);
        chk("t5_clrwin_blk", 1, K_BLK, 2, 0);
        chk("t5_clrwin_trip", 1, K_TRIP, 0, 1);
        quiet();
        do_reset();

        // Dual trip, peak clear, reset mid-run
        thresh = 8'd10;
        valid  = 4'b1001;
        repeat (9) tick();
        chk("t6_trip_pre", 0, K_TRIP, 0, 0);
        chk("t6_any_pre", 0, K_ANY, 0, 0);
        tick();
        chk("t6_blk0", 0, K_BLK, 0, 1);
        chk("t6_blk3", 0, K_BLK, 3, 1);
        chk("t6_any", 0, K_ANY, 0, 1);
        chk("t6_trip2", 0, K_TRIP, 0, 2);
        repeat (2) tick();
        chk("t6_cnt12", 0, K_CNT, 3, 12);
        max_clr = 1'b1;
        tick();
        chk("t6_maxclr0", 0, K_MAX, 0, 0);
        chk("t6_maxclr3", 0, K_MAX, 3, 0);
        chk("t6_cnt13", 0, K_CNT, 0, 13);
        max_clr = 1'b0;
        tick();
        chk("t6_max13", 0, K_MAX, 0, 13);
        chk("t6_cnt14", 0, K_CNT, 0, 14);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_cnt", 0, K_CNT, 0, 0);
        chk("t6_rst_max", 0, K_MAX, 3, 0);
        chk("t6_rst_blk", 0, K_BLK, 3, 0);
        chk("t6_rst_any", 0, K_ANY, 0, 0);
        chk("t6_rst_trip", 0, K_TRIP, 0, 0);
        rst_n = 1'b1;
        quiet();

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
